fft_bfu_pipe: RTL and testbench

//  Pipelined, parametrised radix-2 DIT butterfly unit: aout = a + b*w, bout = a - b*w.

---
 rtl/fft_pkg.sv | 36 +++
 rtl/fft_cmult_pipe.sv | 78 +++++++
 rtl/fft_bfu_pipe.sv | 76 +++++++
 tb/tb_fft_bfu_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: complex type, rounding constant and range helpers for the butterfly; FFT_BFU_SAT_EN selects clamp instead of wrap
package fft_pkg;
    localparam int CW = 16;
    localparam int TWF = 15;
    localparam int ROUND_HALF = 1 << (TWF - 1);
    localparam int FW = 34;

    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } cplx_t;

    function automatic cplx_t unpack(input logic [2*CW-1:0] x);
        return cplx_t'(x);
    endfunction

    function automatic logic [2*CW-1:0] pack(input cplx_t c);
        return {c.re, c.im};
    endfunction

    function automatic logic fits(input logic signed [FW-1:0] s, input int w);
        logic signed [FW-1:0] hi;
        hi = (FW'(1) <<< (w - 1)) - FW'(1);
        return (s <= hi) && (s >= ~hi);
    endfunction

    function automatic logic signed [FW-1:0] fit(input logic signed [FW-1:0] s, input int w);
`ifdef FFT_BFU_SAT_EN
        logic signed [FW-1:0] hi;
        hi = (FW'(1) <<< (w - 1)) - FW'(1);
        return (s > hi) ? hi : ((s < ~hi) ? ~hi : s);
`else
        return (s <<< (FW - w)) >>> (FW - w);
`endif
    endfunction
endpackage

// File: rtl/fft_cmult_pipe.sv
// fft_cmult_pipe: two-stage rounded complex multiply b*w (optionally conj(w)), carrying a and scale alongside
module fft_cmult_pipe #(
    parameter int width   = 16,
    parameter int TW_FRAC = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic                    inverse,
    input  logic                    scale,
    input  logic [2*width-1:0]      twiddle,
    input  logic [2*width-1:0]      a,
    input  logic [2*width-1:0]      b,
    output logic                    v1,
    output logic                    v2,
    output logic                    s2_scale,
    output logic [2*width-1:0]      s2_a,
    output logic signed [width:0]   s2_pr,
    output logic signed [width:0]   s2_pi
);
    localparam int P = 2*width + 2;
    localparam logic signed [P-1:0] RH = P'(1) <<< (TW_FRAC - 1);
    logic [2*width-1:0] a1, b1;
    logic signed [width:0] wr1, wi1, wi_x;
    logic scale1;
    logic signed [P-1:0] br, bi, wr, wi, pr, pi;

    assign wi_x = (width+1)'($signed(twiddle[width-1:0]));

    // S1: capture operands and per-beat mode; conjugate in width+1 bits so -min is exact
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            v1     <= 1'b0;
            a1     <= '0;
            b1     <= '0;
            wr1    <= '0;
            wi1    <= '0;
            scale1 <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1     <= a;
                b1     <= b;
                scale1 <= scale;
                wr1    <= (width+1)'($signed(twiddle[2*width-1:width]));
                wi1    <= inverse ? -wi_x : wi_x;
            end
        end

    // Products with the round-half-up bias already folded in
    always_comb begin
        br = P'($signed(b1[2*width-1:width]));
        bi = P'($signed(b1[width-1:0]));
        wr = P'(wr1);
        wi = P'(wi1);
        pr = br*wr - bi*wi + RH;
        pi = br*wi + bi*wr + RH;
    end

    // S2: drop the twiddle fraction bits and register the product
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            v2       <= 1'b0;
            s2_a     <= '0;
            s2_scale <= 1'b0;
            s2_pr    <= '0;
            s2_pi    <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                s2_a     <= a1;
                s2_scale <= scale1;
                s2_pr    <= (width+1)'(pr >>> TW_FRAC);
                s2_pi    <= (width+1)'(pi >>> TW_FRAC);
            end
        end
endmodule

// File: rtl/fft_bfu_pipe.sv
// fft_bfu_pipe: 3-stage radix-2 DIT butterfly with valid/ready, per-beat IFFT/scale, sticky ovf; FFT_BFU_SAT_EN clamps out-of-range results
module fft_bfu_pipe
    import fft_pkg::*;
#(
    parameter int width   = 16,
    parameter int TW_FRAC = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                inverse,
    input  logic                scale,
    input  logic [2*width-1:0]  twiddle,
    input  logic [2*width-1:0]  a,
    input  logic [2*width-1:0]  b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*width-1:0]  aout,
    output logic [2*width-1:0]  bout,
    output logic                ovf,
    input  logic                clear_ovf,
    output logic                busy
);
    logic en, v1, v2, s2_scale, any_ovf;
    logic [2*width-1:0] s2_a;
    logic signed [width:0] s2_pr, s2_pi;
    logic signed [width+1:0] ar, ai, pr, pi, s_ar, s_ai, s_br, s_bi;

    function automatic logic signed [width+1:0] half(input logic signed [width+1:0] x, input logic h);
        return h ? (x + (width+2)'(1)) >>> 1 : x;
    endfunction

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign busy     = v1 | v2 | out_valid;

    fft_cmult_pipe #(.width(width), .TW_FRAC(TW_FRAC)) u_cmult (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
        .inverse(inverse), .scale(scale), .twiddle(twiddle), .a(a), .b(b),
        .v1(v1), .v2(v2), .s2_scale(s2_scale), .s2_a(s2_a),
        .s2_pr(s2_pr), .s2_pi(s2_pi)
    );

    // S3 arithmetic: butterfly sums, optional rounded halving, per-component range check
    always_comb begin
        ar      = (width+2)'($signed(s2_a[2*width-1:width]));
        ai      = (width+2)'($signed(s2_a[width-1:0]));
        pr      = (width+2)'(s2_pr);
        pi      = (width+2)'(s2_pi);
        s_ar    = half(ar + pr, s2_scale);
        s_ai    = half(ai + pi, s2_scale);
        s_br    = half(ar - pr, s2_scale);
        s_bi    = half(ai - pi, s2_scale);
        any_ovf = !fits(FW'(s_ar), width) || !fits(FW'(s_ai), width) ||
                  !fits(FW'(s_br), width) || !fits(FW'(s_bi), width);
    end

    // S3 output register and sticky overflow; clear wins over a same-cycle set
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            out_valid <= 1'b0;
            aout      <= '0;
            bout      <= '0;
            ovf       <= 1'b0;
        end else begin
            if (en) begin
                out_valid <= v2;
                if (v2) begin
                    aout <= {width'(fit(FW'(s_ar), width)), width'(fit(FW'(s_ai), width))};
                    bout <= {width'(fit(FW'(s_br), width)), width'(fit(FW'(s_bi), width))};
                end
            end
            ovf <= clear_ovf ? 1'b0 : (ovf | (en & v2 & any_ovf));
        end
endmodule

// File: tb/tb_fft_bfu_pipe.sv
// tb_fft_bfu_pipe: directed + backpressure scoreboard bench for the butterfly pipeline
module tb_fft_bfu_pipe;
    import fft_pkg::*;
    logic clk = 1'b0, reset, in_valid, in_ready, inverse, scale, out_valid, out_ready;
    logic ovf, clear_ovf, busy, bp;
    logic [31:0] twiddle, a, b, aout, bout;
    logic [63:0] sb[$];
    int checks = 0, errors = 0;

`ifdef FFT_BFU_SAT_EN
    localparam int OVF_RE = 32767;
`else
    localparam int OVF_RE = -5537;
`endif

    fft_bfu_pipe #(.width(16), .TW_FRAC(15)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .inverse(inverse), .scale(scale), .twiddle(twiddle), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .aout(aout), .bout(bout),
        .ovf(ovf), .clear_ovf(clear_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cx(input int r, input int i);
        cplx_t t;
        t.re = 16'(r);
        t.im = 16'(i);
        return pack(t);
    endfunction

    function automatic logic [63:0] model(input logic [31:0] ma, mb, mw, input logic inv, scl);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        longint s[4];
        logic [15:0] r[4];
        ar = longint'(unpack(ma).re);
        ai = longint'(unpack(ma).im);
        br = longint'(unpack(mb).re);
        bi = longint'(unpack(mb).im);
        wr = longint'(unpack(mw).re);
        wi = longint'(unpack(mw).im);
        if (inv) wi = -wi;
        pr = (br*wr - bi*wi + ROUND_HALF) >>> TWF;
        pi = (br*wi + bi*wr + ROUND_HALF) >>> TWF;
        s[0] = ar + pr; s[1] = ai + pi; s[2] = ar - pr; s[3] = ai - pi;
        for (int k = 0; k < 4; k++) begin
            if (scl) s[k] = (s[k] + 1) >>> 1;
`ifdef FFT_BFU_SAT_EN
            if (s[k] > 32767) s[k] = 32767;
            else if (s[k] < -32768) s[k] = -32768;
`endif
            r[k] = 16'(s[k]);
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] ta, tb_, tw, input logic inv, scl, input logic [63:0] exp);
        int n;
        a = ta; b = tb_; twiddle = tw; inverse = inv; scale = scl; in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", in_ready, 1'b1);
        sb.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: flow-control invariant every cycle, pop/compare on each output transfer
    always @(negedge clk) begin
        logic [63:0] exp;
        #2;
        if (!reset) begin
            checks++;
            assert (in_ready === !(out_valid && !out_ready)) else begin
                errors++;
                $error("FAIL in_ready observed=%b expected=%b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed=%h expected=none", {aout, bout});
                end
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    checks++;
                    assert ({aout, bout} === exp) else begin
                        errors++;
                        $error("FAIL beat observed=%h expected=%h", {aout, bout}, exp);
                    end
                end
            end
        end
    end

    always @(negedge clk) if (bp) out_ready = 1'($urandom_range(0, 1));

    initial begin
        logic [31:0] ra, rb, rw;
        logic ri, rs;
        reset = 1'b1; in_valid = 1'b0; inverse = 1'b0; scale = 1'b0; twiddle = '0;
        a = '0; b = '0; out_ready = 1'b1; clear_ovf = 1'b0; bp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_aout_bout", {aout, bout}, 64'd0);
        reset = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        send(cx(1000, 0), cx(500, 0), cx(32767, 0), 1'b0, 1'b0, {cx(1500, 0), cx(500, 0)});
        @(negedge clk);
        chk("lat_2clk", out_valid, 1'b0);
        @(negedge clk);
        chk("lat_3clk", out_valid, 1'b1);
        drain();
        chk("basic_ovf", ovf, 1'b0);
        send(cx(0, 0), cx(0, 1000), cx(0, 32767), 1'b0, 1'b0, {cx(-1000, 0), cx(1000, 0)});
        send(cx(0, 0), cx(0, 1000), cx(0, 32767), 1'b1, 1'b0, {cx(1000, 0), cx(-1000, 0)});
        drain();
        send(cx(30000, 0), cx(30000, 0), cx(32767, 0), 1'b0, 1'b0, {cx(OVF_RE, 0), cx(1, 0)});
        drain();
        chk("ovf_set", ovf, 1'b1);
        clear_ovf = 1'b1;
        @(negedge clk);
        chk("ovf_clear", ovf, 1'b0);
        clear_ovf = 1'b0;
        send(cx(30000, 0), cx(30000, 0), cx(32767, 0), 1'b0, 1'b1, {cx(30000, 0), cx(1, 0)});
        drain();
        chk("scaled_no_ovf", ovf, 1'b0);
        send(cx(0, 0), cx(-32768, 0), cx(-32768, 0), 1'b0, 1'b1, {cx(16384, 0), cx(-16384, 0)});
        drain();
        chk("edge_no_ovf", ovf, 1'b0);
        bp = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rw = $urandom;
            ri = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            send(ra, rb, rw, ri, rs, model(ra, rb, rw, ri, rs));
        end
        drain();
        bp = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            send(cx(100 + i, 0), cx(10, 0), cx(32767, 0), 1'b0, 1'b0, {cx(110 + i, 0), cx(90 + i, 0)});
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_out_valid", out_valid, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end
        chk("post_rst_ovf", ovf, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
